// File: rtl/riscv_defines.sv
// Shared opcode/state definitions for the hardware-loop register writer.
// Included everywhere the loop-setup command encoding is needed.
package riscv_defines;

  typedef enum logic [1:0] {
    HWLP_OP_START = 2'd0,
    HWLP_OP_END   = 2'd1,
    HWLP_OP_COUNT = 2'd2,
    HWLP_OP_SETUP = 2'd3
  } hwlp_op_e;

  typedef enum logic [0:0] {
    HWLP_IDLE      = 1'b0,
    HWLP_SETUP_END = 1'b1
  } hwlp_state_e;

  // Loop addresses are word aligned; the two low bits are always dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_hwloop_regs_writer_if.sv
// Loop-setup command channel between the decoder (master) and the
// hardware-loop register file (slave).
interface riscv_hwloop_regs_writer_if #(
  parameter int N_REG_BITS = 1
);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_op_i;
  logic [N_REG_BITS-1:0] cmd_regid_i;
  logic [31:0]           cmd_data_i;
  logic [31:0]           cmd_pc_i;
  logic [31:0]           cmd_imm_i;
  logic                  cmd_err_o;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_regid_i,
    output cmd_data_i,
    output cmd_pc_i,
    output cmd_imm_i,
    input  cmd_ready_o,
    input  cmd_err_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_regid_i,
    input  cmd_data_i,
    input  cmd_pc_i,
    input  cmd_imm_i,
    output cmd_ready_o,
    output cmd_err_o
  );

endinterface

// File: rtl/riscv_hwloop_regs_writer.sv
// Hardware-loop start/end/counter register file with a loop-setup command port.
// Define RISCV_HWLP_SETUP_EN to enable the two-cycle SETUP opcode.
module riscv_hwloop_regs_writer
  import riscv_defines::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_hwloop_regs_writer_if.slave cmd,
  output logic [N_REGS-1:0][31:0] hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_counter_o,
  input  logic [N_REGS-1:0]       hwlp_dec_cnt_i,
  input  logic                    id_advance_i,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_id_o
);

`ifdef RISCV_HWLP_SETUP_EN
  localparam bit SetupEn = 1'b1;
`else
  localparam bit SetupEn = 1'b0;
`endif

  hwlp_state_e           state_reg;
  hwlp_state_e           state_next;
  logic                  err_reg;
  logic [31:0]           end_latch_reg;
  logic [N_REG_BITS-1:0] regid_latch_reg;

  hwlp_op_e op;
  logic     ready;
  logic     accept;
  logic     regid_ok;
  logic     op_ok;
  logic     wr_en;
  logic     setup_go;

  assign op       = hwlp_op_e'(cmd.cmd_op_i);
  assign ready    = (state_reg == HWLP_IDLE);
  assign accept   = cmd.cmd_valid_i && ready;
  // Widen by one bit so a power-of-two N_REGS is representable in the compare.
  assign regid_ok = ({1'b0, cmd.cmd_regid_i} < (N_REG_BITS+1)'(N_REGS));
  assign op_ok    = (op != HWLP_OP_SETUP) || SetupEn;
  assign wr_en    = accept && regid_ok && op_ok;
  assign setup_go = wr_en && (op == HWLP_OP_SETUP);

  assign cmd.cmd_ready_o = ready;
  assign cmd.cmd_err_o   = err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HWLP_IDLE:      if (setup_go) state_next = HWLP_SETUP_END;
      HWLP_SETUP_END: state_next = HWLP_IDLE;
      default:        state_next = HWLP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HWLP_IDLE;
      err_reg         <= 1'b0;
      end_latch_reg   <= '0;
      regid_latch_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && !(regid_ok && op_ok);
      if (setup_go) begin
        end_latch_reg   <= cmd.cmd_pc_i + cmd.cmd_imm_i;
        regid_latch_reg <= cmd.cmd_regid_i;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_loop
      logic [31:0] start_reg;
      logic [31:0] end_reg;
      logic [31:0] counter_reg;
      logic        dec_id_reg;
      logic        sel;
      logic        end_fin;

      assign sel     = wr_en && (cmd.cmd_regid_i == N_REG_BITS'(gi));
      assign end_fin = (state_reg == HWLP_SETUP_END) &&
                       (regid_latch_reg == N_REG_BITS'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          start_reg   <= '0;
          end_reg     <= '0;
          counter_reg <= '0;
          dec_id_reg  <= 1'b0;
        end else begin
          if (sel && op == HWLP_OP_START)
            start_reg <= word_align(cmd.cmd_data_i);
          else if (sel && op == HWLP_OP_SETUP)
            start_reg <= word_align(cmd.cmd_pc_i + 32'd4);

          if (sel && op == HWLP_OP_END)
            end_reg <= word_align(cmd.cmd_data_i);
          else if (end_fin)
            end_reg <= word_align(end_latch_reg);

          // A software write overrides a concurrent decrement; decrements saturate at 0.
          if (sel && (op == HWLP_OP_COUNT || op == HWLP_OP_SETUP))
            counter_reg <= cmd.cmd_data_i;
          else if (hwlp_dec_cnt_i[gi] && counter_reg != 32'd0)
            counter_reg <= counter_reg - 32'd1;

          if (hwlp_dec_cnt_i[gi])
            dec_id_reg <= 1'b1;
          else if (id_advance_i)
            dec_id_reg <= 1'b0;
        end
      end

      assign hwlp_start_addr_o[gi] = start_reg;
      assign hwlp_end_addr_o[gi]   = end_reg;
      assign hwlp_counter_o[gi]    = counter_reg;
      assign hwlp_dec_cnt_id_o[gi] = dec_id_reg;
    end
  endgenerate

endmodule

// File: tb/tb_riscv_hwloop_regs_writer.sv
// Directed table-driven bench for riscv_hwloop_regs_writer (N_REGS=2, 2-bit regid
// so out-of-range indices can be driven).
module tb_riscv_hwloop_regs_writer;

  typedef struct {
    string       name;
    logic        valid;
    logic [1:0]  op;
    logic [1:0]  regid;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  dec;
    logic        adv;
    logic [31:0] s0, s1, e0, e1, c0, c1;
    logic        rdy;
    logic        err;
    logic [1:0]  decid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][31:0] start_addr, end_addr, counter;
  logic [1:0] dec_cnt;
  logic       id_advance;
  logic [1:0] dec_cnt_id;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  riscv_hwloop_regs_writer_if #(.N_REG_BITS(2)) cmd_if();

  riscv_hwloop_regs_writer #(.N_REGS(2), .N_REG_BITS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd               (cmd_if),
    .hwlp_start_addr_o (start_addr),
    .hwlp_end_addr_o   (end_addr),
    .hwlp_counter_o    (counter),
    .hwlp_dec_cnt_i    (dec_cnt),
    .id_advance_i      (id_advance),
    .hwlp_dec_cnt_id_o (dec_cnt_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_state(input vec_t v);
    check({v.name, ".start0"}, start_addr[0], v.s0);
    check({v.name, ".start1"}, start_addr[1], v.s1);
    check({v.name, ".end0"},   end_addr[0],   v.e0);
    check({v.name, ".end1"},   end_addr[1],   v.e1);
    check({v.name, ".cnt0"},   counter[0],    v.c0);
    check({v.name, ".cnt1"},   counter[1],    v.c1);
    check({v.name, ".ready"},  {31'd0, cmd_if.cmd_ready_o}, {31'd0, v.rdy});
    check({v.name, ".err"},    {31'd0, cmd_if.cmd_err_o},   {31'd0, v.err});
    check({v.name, ".decid"},  {30'd0, dec_cnt_id},         {30'd0, v.decid});
  endtask

  task automatic drive(input vec_t v);
    cmd_if.cmd_valid_i = v.valid;
    cmd_if.cmd_op_i    = v.op;
    cmd_if.cmd_regid_i = v.regid;
    cmd_if.cmd_data_i  = v.data;
    cmd_if.cmd_pc_i    = v.pc;
    cmd_if.cmd_imm_i   = v.imm;
    dec_cnt            = v.dec;
    id_advance         = v.adv;
  endtask

  function automatic vec_t mk(input string name, input logic valid, input logic [1:0] op,
                              input logic [1:0] regid, input logic [31:0] data,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [1:0] dec, input logic adv,
                              input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] c0, input logic [31:0] c1,
                              input logic rdy, input logic err, input logic [1:0] decid);
    vec_t v;
    v.name = name; v.valid = valid; v.op = op; v.regid = regid; v.data = data;
    v.pc = pc; v.imm = imm; v.dec = dec; v.adv = adv;
    v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1; v.c0 = c0; v.c1 = c1;
    v.rdy = rdy; v.err = err; v.decid = decid;
    return v;
  endfunction

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);

    // Expected columns: state visible one cycle after the vector is applied.
    //              name          vld op rid data          pc         imm          dec   adv  s0       s1       e0       e1       c0  c1  rdy err decid
    vecs.push_back(mk("start_r0",  1, 0, 0, 32'h103,      0,         0,           2'b00, 0, 32'h100, 0,       0,       0,       0,  0,  1,  0,  2'b00));
    vecs.push_back(mk("hold",      0, 0, 0, 0,            0,         0,           2'b00, 0, 32'h100, 0,       0,       0,       0,  0,  1,  0,  2'b00));
    vecs.push_back(mk("count_r1",  1, 2, 1, 3,            0,         0,           2'b00, 0, 32'h100, 0,       0,       0,       0,  3,  1,  0,  2'b00));
    vecs.push_back(mk("dec1_a",    0, 0, 0, 0,            0,         0,           2'b10, 0, 32'h100, 0,       0,       0,       0,  2,  1,  0,  2'b10));
    vecs.push_back(mk("dec1_b",    0, 0, 0, 0,            0,         0,           2'b10, 0, 32'h100, 0,       0,       0,       0,  1,  1,  0,  2'b10));
    vecs.push_back(mk("dec1_c",    0, 0, 0, 0,            0,         0,           2'b10, 0, 32'h100, 0,       0,       0,       0,  0,  1,  0,  2'b10));
    vecs.push_back(mk("dec1_sat",  0, 0, 0, 0,            0,         0,           2'b10, 0, 32'h100, 0,       0,       0,       0,  0,  1,  0,  2'b10));
    vecs.push_back(mk("advance",   0, 0, 0, 0,            0,         0,           2'b00, 1, 32'h100, 0,       0,       0,       0,  0,  1,  0,  2'b00));
    vecs.push_back(mk("end_r1",    1, 1, 1, 32'h2FF,      0,         0,           2'b00, 0, 32'h100, 0,       0,       32'h2FC, 0,  0,  1,  0,  2'b00));
    vecs.push_back(mk("cnt_vs_dec",1, 2, 0, 7,            0,         0,           2'b01, 0, 32'h100, 0,       0,       32'h2FC, 7,  0,  1,  0,  2'b01));
    vecs.push_back(mk("decid_hold",0, 0, 0, 0,            0,         0,           2'b00, 0, 32'h100, 0,       0,       32'h2FC, 7,  0,  1,  0,  2'b01));
    vecs.push_back(mk("decid_clr", 0, 0, 0, 0,            0,         0,           2'b00, 1, 32'h100, 0,       0,       32'h2FC, 7,  0,  1,  0,  2'b00));
    vecs.push_back(mk("dec_both",  0, 0, 0, 0,            0,         0,           2'b11, 1, 32'h100, 0,       0,       32'h2FC, 6,  0,  1,  0,  2'b11));
    vecs.push_back(mk("bad_rid2",  1, 0, 2, 32'h500,      0,         0,           2'b00, 0, 32'h100, 0,       0,       32'h2FC, 6,  0,  1,  1,  2'b11));
    vecs.push_back(mk("bad_rid3",  1, 2, 3, 9,            0,         0,           2'b00, 1, 32'h100, 0,       0,       32'h2FC, 6,  0,  1,  1,  2'b00));
    vecs.push_back(mk("err_clear", 0, 0, 0, 0,            0,         0,           2'b00, 0, 32'h100, 0,       0,       32'h2FC, 6,  0,  1,  0,  2'b00));
    vecs.push_back(mk("start_r1",  1, 0, 1, 32'h7FF,      0,         0,           2'b00, 0, 32'h100, 32'h7FC, 0,       32'h2FC, 6,  0,  1,  0,  2'b00));
`ifdef RISCV_HWLP_SETUP_EN
    vecs.push_back(mk("setup_r0",  1, 3, 0, 5,            32'h200,   32'h20,      2'b00, 0, 32'h204, 32'h7FC, 0,       32'h2FC, 5,  0,  0,  0,  2'b00));
    vecs.push_back(mk("setup_end", 0, 0, 0, 0,            0,         0,           2'b00, 0, 32'h204, 32'h7FC, 32'h220, 32'h2FC, 5,  0,  1,  0,  2'b00));
    vecs.push_back(mk("setup_r1",  1, 3, 1, 2,            32'h1000,  32'hFFFFFFF0,2'b00, 0, 32'h204, 32'h1004,32'h220, 32'h2FC, 5,  2,  0,  0,  2'b00));
    vecs.push_back(mk("busy_drop", 1, 2, 0, 99,           0,         0,           2'b00, 0, 32'h204, 32'h1004,32'h220, 32'hFF0, 5,  2,  1,  0,  2'b00));
`else
    vecs.push_back(mk("setup_off", 1, 3, 0, 5,            32'h200,   32'h20,      2'b00, 0, 32'h100, 32'h7FC, 0,       32'h2FC, 6,  0,  1,  1,  2'b00));
    vecs.push_back(mk("setup_off2",0, 0, 0, 0,            0,         0,           2'b00, 0, 32'h100, 32'h7FC, 0,       32'h2FC, 6,  0,  1,  0,  2'b00));
`endif

    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle.name = "reset";
    check_state(idle);
    $display("[TB] reset checked");
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_state(vecs[i]);
      $display("[TB] vec %0d %s op=%0d regid=%0d data=0x%08h dec=%b adv=%b", i, vecs[i].name,
               vecs[i].op, vecs[i].regid, vecs[i].data, vecs[i].dec, vecs[i].adv);
    end

    // Reset in the middle of a loop setup must leave nothing behind.
    v = mk("rst_mid", 1, 3, 1, 4, 32'h300, 32'h8, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    drive(v);
    @(posedge clk);
    #1;
`ifdef RISCV_HWLP_SETUP_EN
    check("rst_mid.busy", {31'd0, cmd_if.cmd_ready_o}, 32'd0);
`else
    check("rst_mid.err", {31'd0, cmd_if.cmd_err_o}, 32'd1);
`endif
    drive(idle);
    rst = 1'b1;
    @(posedge clk);
    #1;
    v = idle;
    v.name = "rst_mid_reset";
    check_state(v);
    rst = 1'b0;
    @(posedge clk);
    #1;
    v.name = "rst_mid_after";
    check_state(v);
    $display("[TB] reset during setup checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_regs_writer.md
RISCV_HWLOOP_REGS_WRITER -- requirements
Module: riscv_hwloop_regs_writer

Interface
REQ-001 SHALL have parameter N_REGS, default 2, number of hardware-loop register sets.
REQ-002 SHALL have parameter N_REG_BITS, default $clog2(N_REGS) (minimum 1), width of the loop index.
REQ-003 SHALL have port clk  input  1  sole clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid_i  input  1  loop-setup command valid.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when valid && ready.
REQ-007 SHALL have port cmd_op_i  input  2  opcode: 0 START, 1 END, 2 COUNT, 3 SETUP.
REQ-008 SHALL have port cmd_regid_i  input  N_REG_BITS  target loop index.
REQ-009 SHALL have port cmd_data_i  input  32  address for START/END; count for COUNT/SETUP.
REQ-010 SHALL have port cmd_pc_i  input  32  PC of the SETUP instruction.
REQ-011 SHALL have port cmd_imm_i  input  32  sign-extended end offset for SETUP.
REQ-012 SHALL have port cmd_err_o  output  1  one-cycle pulse: command rejected.
REQ-013 SHALL have port hwlp_start_addr_o  output  N_REGS x 32  stored start addresses.
REQ-014 SHALL have port hwlp_end_addr_o  output  N_REGS x 32  stored end addresses.
REQ-015 SHALL have port hwlp_counter_o  output  N_REGS x 32  stored iteration counters.
REQ-016 SHALL have port hwlp_dec_cnt_i  input  N_REGS  decrement request from the loop controller.
REQ-017 SHALL have port id_advance_i  input  1  ID-stage instruction leaves ID this cycle.
REQ-018 SHALL have port hwlp_dec_cnt_id_o  output  N_REGS  decrement in flight for the instruction still in ID.

Function
REQ-019 SHALL implement FSM IDLE, SETUP_END; cmd_ready_o = 1 only in IDLE.
REQ-020 In IDLE, on an accepted START/END, SHALL write cmd_data_i with bits [1:0] forced to 0 into register cmd_regid_i at the next edge.
REQ-021 In IDLE, on an accepted COUNT, SHALL write cmd_data_i unchanged into counter cmd_regid_i at the next edge.
REQ-022 In IDLE, on an accepted SETUP, SHALL write start = cmd_pc_i+4 (bits [1:0]=0) and counter = cmd_data_i, latch cmd_pc_i+cmd_imm_i and regid, and go to SETUP_END.
REQ-023 In SETUP_END, SHALL write the latched end address (bits [1:0]=0) and return to IDLE; a SETUP therefore takes 2 cycles.
REQ-024 cmd_regid_i >= N_REGS SHALL produce no write, a cmd_err_o pulse in the cycle after acceptance, and stay in IDLE.
REQ-025 hwlp_dec_cnt_i[i] SHALL decrement counter i by 1 at the next edge; at 0 it SHALL saturate, never wrap.
REQ-026 A COUNT/SETUP write to loop i in the same cycle as hwlp_dec_cnt_i[i] SHALL take the write value; the decrement is dropped.
REQ-027 Decrements on several loops in one cycle SHALL all be applied independently.
REQ-028 hwlp_dec_cnt_id_o[i] SHALL set on hwlp_dec_cnt_i[i] and clear on id_advance_i without a new decrement; set SHALL win over clear.
REQ-029 Register outputs SHALL be registered and reflect writes one cycle after the write edge, with no combinational bypass.

Reset
REQ-030 On rst, all start, end and counter registers SHALL be 0; FSM SHALL be IDLE; cmd_ready_o SHALL be 1; cmd_err_o and hwlp_dec_cnt_id_o SHALL be 0.
REQ-031 rst in SETUP_END SHALL abandon the pending end write; no partial state beyond reset values SHALL remain.

Configuration
REQ-032 Macro RISCV_HWLP_SETUP_EN SHALL enable the SETUP opcode and the SETUP_END state.
REQ-033 Without RISCV_HWLP_SETUP_EN, SETUP SHALL be rejected with a cmd_err_o pulse and no write, and the FSM SHALL reduce to IDLE.

Structure
REQ-034 Opcode enum (START/END/COUNT/SETUP) and FSM state enum SHALL live in the shared riscv_defines package.
REQ-035 No sub-module is needed; per-loop counter logic SHALL be a generate loop.

Verification
REQ-036 Reset, then START r0=0x103 -> hwlp_start_addr_o[0]=0x100 the next cycle; others 0.
REQ-037 COUNT r1=3, then hwlp_dec_cnt_i[1] for 4 cycles -> counter 2,1,0,0 (saturated).
REQ-038 SETUP r0, pc=0x200, imm=0x20, data=5 -> start 0x204 and counter 5, then end 0x220 a cycle later; cmd_ready_o low for 1 cycle.
REQ-039 COUNT r0=7 with hwlp_dec_cnt_i[0]=1 in the same cycle -> counter 7; hwlp_dec_cnt_id_o[0]=1 until id_advance_i.
REQ-040 regid=2 with N_REGS=2 -> cmd_err_o pulse, all registers unchanged; with the macro off, SETUP -> cmd_err_o pulse.
